uart_rx_ctrl: RTL

Receive-side controller placed between the UART receiver and the CPU peripheral bus. It detects each completed-byte pulse from the receiver and pushes the byte into a small FIFO. It also exposes data, status and control registers to the CPU and raises a level interrupt. Everything runs in the sysclk domain, alongside the other memory-mapped peripherals.

---
 rtl/uart_rx_ctrl_if.sv | 12 +
 rtl/uart_rx_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// CPU register bus of uart_rx_ctrl: one-cycle rd/wr strobes, combinational rdata, level irq.
interface uart_rx_ctrl_if;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output rd, wr, addr, wdata, input rdata, irq);
    modport slave  (input rd, wr, addr, wdata, output rdata, irq);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte capture FSM, RX FIFO, CPU registers and level irq.
// Optional idle-timeout flag is built only when RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH_LOG2     = 3,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                rx_status,
    input  logic [7:0]          rx_data,
    uart_rx_ctrl_if.slave       bus,
    output logic [DEPTH_LOG2:0] fifo_count,
    output logic                cap_state
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} cap_state_e;
    cap_state_e state, state_nxt;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rptr, wptr;
    logic [DEPTH_LOG2:0]   count;
    logic [3:0]            ctrl;
    logic                  ovf, tmo, irq_q;
    logic                  not_empty, full;
    logic                  push_req, push_ok, pop, flush, ovf_set, ovf_clr;
    logic                  unused_wdata;

    // Handshake: rd/wr are single-cycle qualifiers with no ready; rdata is valid whenever
    // addr is stable, and rd only adds the pop side effect at the closing clock edge.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        case (state)
            IDLE: if (rx_status) begin
                state_nxt = HOLD;
                push_req  = ctrl[0];
            end
            HOLD: if (!rx_status) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign not_empty    = (count != '0);
    assign full         = (count == CNT_FULL);
    assign pop          = bus.rd && (bus.addr == 2'd0) && not_empty;
    assign flush        = bus.wr && (bus.addr == 2'd2) && bus.wdata[4];
    // A pop in the same edge frees the slot, so a full FIFO still accepts the byte.
    assign push_ok      = push_req && !flush && (!full || pop);
    assign ovf_set      = push_req && !flush && full && !pop;
    assign ovf_clr      = bus.wr && (bus.addr == 2'd1) && bus.wdata[2];
    assign unused_wdata = ^bus.wdata[31:5];

`ifdef RX_TIMEOUT_EN
    localparam logic TMO_IMPL = 1'b1;
    logic [15:0] idle_cnt;
    logic        idle_clr, tmo_set, tmo_clr;

    assign idle_clr = push_ok || pop || flush || !not_empty;
    assign tmo_set  = !idle_clr && (idle_cnt == TIMEOUT_CYCLES - 16'd1);
    assign tmo_clr  = bus.wr && (bus.addr == 2'd1) && bus.wdata[3];

    // Counter saturates, so tmo sets only once per idle stretch.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
            tmo      <= 1'b0;
        end else begin
            if (idle_clr)                        idle_cnt <= '0;
            else if (idle_cnt != TIMEOUT_CYCLES) idle_cnt <= idle_cnt + 16'd1;
            if (tmo_set)      tmo <= 1'b1;
            else if (tmo_clr) tmo <= 1'b0;
        end
    end
`else
    localparam logic TMO_IMPL = 1'b0;
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            ctrl  <= '0;
            irq_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (push_ok) wptr <= wptr + PTR_ONE;
                if (pop)     rptr <= rptr + PTR_ONE;
                if (push_ok && !pop)      count <= count + CNT_ONE;
                else if (pop && !push_ok) count <= count - CNT_ONE;
            end
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (bus.wr && (bus.addr == 2'd2))
                ctrl <= {bus.wdata[3] & TMO_IMPL, bus.wdata[2:0]};
            irq_q <= (ctrl[1] & not_empty) | (ctrl[2] & ovf) | (ctrl[3] & tmo);
        end
    end

    always_ff @(posedge sysclk) begin
        if (push_ok) mem[wptr] <= rx_data;
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            2'd0: if (not_empty) bus.rdata[8:0] = {1'b1, mem[rptr]};
            2'd1: begin
                bus.rdata[0]                = not_empty;
                bus.rdata[1]                = full;
                bus.rdata[2]                = ovf;
                bus.rdata[3]                = tmo;
                bus.rdata[DEPTH_LOG2+8:8]   = count;
            end
            2'd2: bus.rdata[3:0] = ctrl;
            default: bus.rdata = '0;
        endcase
    end

    assign bus.irq    = irq_q;
    assign fifo_count = count;
    assign cap_state  = state;
endmodule
